// File: rtl/glb_stream_read.sv
// GLB valid/ready stream receiver: buffers length-prefixed sparse streams,
// counts completed tiles and exposes a registered readback port.
module glb_stream_read #(
   parameter int unsigned DEPTH      = 2048,
   parameter int unsigned TX_NUM     = 1,
   parameter bit          STALL_EN   = 1'b0,
   parameter logic [15:0] STALL_SEED = 16'hACE1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [16:0]              data,
   input  logic                     valid,
   output logic                     ready,
   input  logic                     flush,
   input  logic                     seg_mode,
   output logic                     done,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   word_count,
   output logic [15:0]              tile_count,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [16:0]              rd_data
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned WW = 17;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_LEN, S_BODY, S_DONE} state_t;

   state_t         state;
   logic [15:0]    lfsr;
   logic [15:0]    rem;
   logic [1:0]     streams_left;
   logic [WW-1:0]  mem [DEPTH];

   logic           xfer;
   logic           full;
   logic           wr_en;
   logic           stream_end;
   logic           tile_end;
   logic           last_tile;
   logic [1:0]     sl_cur;
   logic [1:0]     sl_next;

   // ready never looks at valid; the LFSR only gates it when stalling is enabled
   assign ready = ((state == S_LEN) || (state == S_BODY)) && !(STALL_EN && lfsr[0]);
   assign xfer  = valid && ready;
   assign full  = (word_count == CW'(DEPTH));
   assign wr_en = xfer && !full;

   // streams_left == 0 in LEN marks the first stream of a tile
   assign sl_cur     = ((state == S_LEN) && (streams_left == 2'd0))
                       ? (seg_mode ? 2'd2 : 2'd1) : streams_left;
   assign sl_next    = sl_cur - 2'd1;
   assign stream_end = xfer && (((state == S_LEN) && (data[15:0] == 16'd0)) ||
                                ((state == S_BODY) && (rem == 16'd1)));
   assign tile_end   = stream_end && (sl_next == 2'd0);
   assign last_tile  = ((17'(tile_count) + 17'd1) == 17'(TX_NUM));

   // 16-bit Fibonacci LFSR, taps 16,14,13,11
   always_ff @(posedge clk) begin
      if (rst_n) lfsr <= STALL_SEED;
      else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state        <= S_IDLE;
         done         <= 1'b0;
         overflow     <= 1'b0;
         word_count   <= '0;
         tile_count   <= '0;
         rem          <= '0;
         streams_left <= '0;
      end else begin
         if (xfer) begin
            if (full) overflow   <= 1'b1;
            else      word_count <= word_count + CW'(1);
         end
         case (state)
            S_FLUSH: begin
               word_count   <= '0;
               tile_count   <= '0;
               done         <= 1'b0;
               overflow     <= 1'b0;
               rem          <= '0;
               streams_left <= '0;
               state        <= S_LEN;
            end
            S_LEN: begin
               if (xfer) begin
                  streams_left <= sl_cur;
                  if (data[15:0] != 16'd0) begin
                     rem   <= data[15:0];
                     state <= S_BODY;
                  end
               end
            end
            S_BODY: begin
               if (xfer) rem <= rem - 16'd1;
            end
            default: ;
         endcase
         if (stream_end) begin
            streams_left <= sl_next;
            state        <= S_LEN;
            if (tile_end) begin
               tile_count <= tile_count + 16'd1;
               if (last_tile) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
         end
         // flush wins over every other transition, including staying in FLUSH
         if (flush) state <= S_FLUSH;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[word_count[AW-1:0]] <= data;
   end

   // read-before-write on address collision
   always_ff @(posedge clk) begin
      if (rst_n) rd_data <= '0;
      else       rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_glb_stream_read.sv
// Bench for glb_stream_read: three parameterisations share a clock; readback
// expectations go through a scoreboard queue checked by a separate monitor.
module tb_glb_stream_read;

   logic        clk = 1'b0;
   logic        rst;
   logic        v    [3];
   logic [16:0] d    [3];
   logic        fl   [3];
   logic        sm   [3];
   logic        rdy  [3];
   logic        dn   [3];
   logic        ov   [3];
   logic [15:0] tc   [3];
   logic [16:0] rdd  [3];
   logic [5:0]  wc0, wc1;
   logic [3:0]  wc2;
   logic [4:0]  ra;

   int n_chk  = 0;
   int n_fail = 0;
   int waits  = 0;

   logic        rd_req = 1'b0;
   logic        rd_req_q = 1'b0;
   int          rd_sel = 0;
   int          rd_sel_q = 0;
   logic [16:0] exp_q [$];

   always #5 clk = ~clk;

   glb_stream_read #(.DEPTH(32), .TX_NUM(1), .STALL_EN(1'b0)) dut_a (
      .clk(clk), .rst_n(rst), .data(d[0]), .valid(v[0]), .ready(rdy[0]),
      .flush(fl[0]), .seg_mode(sm[0]), .done(dn[0]), .overflow(ov[0]),
      .word_count(wc0), .tile_count(tc[0]), .rd_addr(ra), .rd_data(rdd[0]));

   glb_stream_read #(.DEPTH(32), .TX_NUM(3), .STALL_EN(1'b1), .STALL_SEED(16'hACE1)) dut_b (
      .clk(clk), .rst_n(rst), .data(d[1]), .valid(v[1]), .ready(rdy[1]),
      .flush(fl[1]), .seg_mode(sm[1]), .done(dn[1]), .overflow(ov[1]),
      .word_count(wc1), .tile_count(tc[1]), .rd_addr(ra), .rd_data(rdd[1]));

   glb_stream_read #(.DEPTH(8), .TX_NUM(1), .STALL_EN(1'b0)) dut_c (
      .clk(clk), .rst_n(rst), .data(d[2]), .valid(v[2]), .ready(rdy[2]),
      .flush(fl[2]), .seg_mode(sm[2]), .done(dn[2]), .overflow(ov[2]),
      .word_count(wc2), .tile_count(tc[2]), .rd_addr(ra[2:0]), .rd_data(rdd[2]));

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int wc(input int k);
      case (k)
         0:       return int'(wc0);
         1:       return int'(wc1);
         default: return int'(wc2);
      endcase
   endfunction

   function automatic logic [16:0] pay(input int i);
      logic [15:0] lo;
      lo = 16'(32'hA000 + i * 3);
      return {i[0], lo};
   endfunction

   // readback monitor: rd_data is valid one edge after the request
   always @(posedge clk) begin
      rd_req_q <= rd_req;
      rd_sel_q <= rd_sel;
   end

   always @(negedge clk) begin
      if (rd_req_q) begin
         if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
         else chk("readback", int'(rdd[rd_sel_q]), int'(exp_q.pop_front()));
      end
   end

   task automatic readback(input int k, input int addr, input logic [16:0] e);
      ra     = 5'(addr);
      rd_sel = k;
      rd_req = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic do_flush(input int k, input int cycles);
      fl[k] = 1'b1;
      repeat (cycles) @(negedge clk);
      fl[k] = 1'b0;
      @(negedge clk);
   endtask

   task automatic send(input int k, input logic [16:0] w);
      int n;
      n = 0;
      v[k] = 1'b1;
      d[k] = w;
      while (!rdy[k] && n < 200) begin
         @(negedge clk);
         n++;
      end
      waits += n;
      if (!rdy[k]) chk("send_timeout", 0, 1);
      @(negedge clk);
      v[k] = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ra  = '0;
      for (int k = 0; k < 3; k++) begin
         v[k] = 1'b0; d[k] = '0; fl[k] = 1'b0; sm[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_ready",    int'(rdy[0]), 0);
      chk("rst_done",     int'(dn[0]),  0);
      chk("rst_overflow", int'(ov[2]),  0);
      chk("rst_wc",       wc(0),        0);
      chk("rst_tc",       int'(tc[1]),  0);
      chk("rst_rd_data",  int'(rdd[0]), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", int'(rdy[0]), 0);

      // basic single stream
      do_flush(0, 1);
      waits = 0;
      send(0, 17'd3);
      send(0, 17'h0000A);
      send(0, 17'h1000B);
      chk("t1_done_early", int'(dn[0]), 0);
      send(0, 17'h0000C);
      chk("t1_no_wait", waits, 0);
      chk("t1_done", int'(dn[0]), 1);
      chk("t1_wc", wc(0), 4);
      chk("t1_tc", int'(tc[0]), 1);
      chk("t1_ready_done", int'(rdy[0]), 0);
      readback(0, 0, 17'd3);
      readback(0, 1, 17'h0000A);
      readback(0, 2, 17'h1000B);
      readback(0, 3, 17'h0000C);

      // seg_mode tile: two streams per tile
      do_flush(0, 1);
      chk("t2_flush_wc", wc(0), 0);
      chk("t2_flush_done", int'(dn[0]), 0);
      sm[0] = 1'b1;
      send(0, 17'd2); send(0, 17'd0); send(0, 17'd5);
      chk("t2_tc_after_s0", int'(tc[0]), 0);
      send(0, 17'd3); send(0, 17'd0); send(0, 17'd1);
      chk("t2_tc_w6", int'(tc[0]), 0);
      chk("t2_done_w6", int'(dn[0]), 0);
      send(0, 17'd2);
      sm[0] = 1'b0;
      chk("t2_tc", int'(tc[0]), 1);
      chk("t2_done", int'(dn[0]), 1);
      chk("t2_wc", wc(0), 7);
      readback(0, 2, 17'd5);
      readback(0, 3, 17'd3);
      readback(0, 6, 17'd2);

      // flush mid-stream, then the next word is a length word
      do_flush(0, 1);
      send(0, 17'd10);
      for (int i = 0; i < 5; i++) send(0, 17'(32'h100 + i));
      chk("t3_wc_mid", wc(0), 6);
      fl[0] = 1'b1;
      @(negedge clk);
      chk("t3_ready_fl1", int'(rdy[0]), 0);
      @(negedge clk);
      fl[0] = 1'b0;
      chk("t3_ready_fl2", int'(rdy[0]), 0);
      chk("t3_wc_clr", wc(0), 0);
      chk("t3_tc_clr", int'(tc[0]), 0);
      @(negedge clk);
      send(0, 17'd2); send(0, 17'h00011); send(0, 17'h00022);
      chk("t3_done", int'(dn[0]), 1);
      chk("t3_wc", wc(0), 3);
      readback(0, 0, 17'd2);
      readback(0, 2, 17'h00022);

      // zero-length streams and multi-tile done (with stalls)
      do_flush(1, 1);
      send(1, 17'd0);
      chk("t4_tc1", int'(tc[1]), 1);
      send(1, 17'd0);
      chk("t4_tc2", int'(tc[1]), 2);
      chk("t4_done_early", int'(dn[1]), 0);
      send(1, 17'd1);
      send(1, 17'h1ABCD);
      chk("t4_tc3", int'(tc[1]), 3);
      chk("t4_done", int'(dn[1]), 1);
      chk("t4_wc", wc(1), 4);
      v[1] = 1'b1; d[1] = 17'd5;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_ready_after_done", int'(rdy[1]), 0);
      end
      v[1] = 1'b0;
      chk("t4_wc_hold", wc(1), 4);
      readback(1, 3, 17'h1ABCD);

      // backpressure: 20-word stream with gappy valid
      do_flush(1, 1);
      waits = 0;
      send(1, 17'd19);
      for (int i = 0; i < 19; i++) begin
         send(1, pay(i));
         if (i % 3 == 1) repeat (2) @(negedge clk);
      end
      chk("t5_stalls_seen", int'(waits > 0), 1);
      chk("t5_wc", wc(1), 20);
      chk("t5_tc", int'(tc[1]), 1);
      chk("t5_done", int'(dn[1]), 0);
      readback(1, 0, 17'd19);
      for (int i = 0; i < 19; i++) readback(1, i + 1, pay(i));

      // overflow on an 8-deep buffer
      do_flush(2, 1);
      send(2, 17'd9);
      for (int i = 1; i <= 7; i++) send(2, 17'(32'h200 + i));
      chk("t6_wc_full", wc(2), 8);
      chk("t6_ov_early", int'(ov[2]), 0);
      send(2, 17'h00208);
      chk("t6_ov", int'(ov[2]), 1);
      chk("t6_wc_sat", wc(2), 8);
      chk("t6_done_early", int'(dn[2]), 0);
      send(2, 17'h00209);
      chk("t6_done", int'(dn[2]), 1);
      chk("t6_tc", int'(tc[2]), 1);
      chk("t6_ov_sticky", int'(ov[2]), 1);
      readback(2, 0, 17'd9);
      readback(2, 7, 17'h00207);

      @(negedge clk);
      @(negedge clk);
      chk("sb_drain", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
